stage_mem_bank: RTL



---
 rtl/stage_mem_bank.sv | 76 +++++++
 1 files changed

// File: rtl/stage_mem_bank.sv
// stage_mem_bank: parametrised tap/bias/data memory with 1- or 2-cycle reads and an optional
// ping-pong pair of banks exchanged by a drain-safe swap handshake.
module stage_mem_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int RD_LAT = 1,
  parameter int PINGPONG = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              bank_sel,
  output logic              err_addr
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [WIDTH-1:0] d1;
  logic v1, wb, rb, wr_ok, rd_ok, fwd, empty, drain, go;
  assign wb = (PINGPONG != 0) && bank_sel;
  assign rb = (PINGPONG != 0) && !bank_sel;
  assign wr_ok = {1'b0, wr_addr} < DEPTH_L;
  assign rd_ok = {1'b0, rd_addr} < DEPTH_L;
  assign fwd = (PINGPONG == 0) && wr_en && wr_ok && wr_addr == rd_addr;
  assign drain = (PINGPONG == 0) || (empty && !rd_en);
  assign go = (state == PEND || swap_req) && drain;
  always_ff @(posedge clk)
    if (wr_en && wr_ok) mem[wb][wr_addr] <= wr_data;
  always_ff @(posedge clk)
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_en;
      if (rd_en) d1 <= !rd_ok ? '0 : fwd ? wr_data : mem[rb][rd_addr];
    end
  if (RD_LAT == 2) begin : g_out
    always_ff @(posedge clk)
      if (reset) begin
        rd_valid <= 1'b0;
        rd_data <= '0;
      end else begin
        rd_valid <= v1;
        if (v1) rd_data <= d1;
      end
    assign empty = !v1 && !rd_valid;
  end else begin : g_dir
    assign rd_valid = v1;
    assign rd_data = d1;
    assign empty = !v1;
  end
  always_ff @(posedge clk)
    if (reset) err_addr <= 1'b0;
    else if ((wr_en && !wr_ok) || (rd_en && !rd_ok)) err_addr <= 1'b1;
  // The bank only flips once every issued read has been presented, so no read straddles a swap.
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      swap_ack <= 1'b0;
      bank_sel <= 1'b0;
    end else begin
      state <= ((state == PEND || swap_req) && !drain) ? PEND : IDLE;
      swap_ack <= go;
      if (go && PINGPONG != 0) bank_sel <= !bank_sel;
    end
endmodule
